// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit.
// Contents: op-code constants, default latencies, 64-bit result type, FSM state type.
// Optional feature macro used by the unit: MDU_MADD_EN (MADD/MADDU/MSUB/MSUBU).
package mdu_pkg;

   localparam logic [3:0] MDU_NOP   = 4'd0;
   localparam logic [3:0] MDU_MULT  = 4'd1;
   localparam logic [3:0] MDU_MULTU = 4'd2;
   localparam logic [3:0] MDU_DIV   = 4'd3;
   localparam logic [3:0] MDU_DIVU  = 4'd4;
   localparam logic [3:0] MDU_MTHI  = 4'd5;
   localparam logic [3:0] MDU_MTLO  = 4'd6;
   localparam logic [3:0] MDU_MADD  = 4'd7;
   localparam logic [3:0] MDU_MADDU = 4'd8;
   localparam logic [3:0] MDU_MSUB  = 4'd9;
   localparam logic [3:0] MDU_MSUBU = 4'd10;

   localparam int unsigned MULT_LAT_DEF = 5;
   localparam int unsigned DIV_LAT_DEF  = 10;

   typedef logic [63:0] dword_t;

   typedef enum logic [0:0] {StIdle, StRun} mdu_state_e;

endpackage

// File: rtl/mdu_calc.sv
// Purely combinational result computation for the multiply/divide unit.
// Optional feature macro: MDU_MADD_EN enables the accumulate ops (7-10).
// Ports:
//   op       in   4   operation code
//   a, b     in   32  rs/rt operands after forwarding
//   hi, lo   in   32  current HI/LO (accumulate source)
//   res      out  64  {hi,lo} result to be latched as the pending result
//   div_zero out  1   divide-class op with b==0 (result must not commit)
//   is_long  out  1   op occupies the unit for a multi-cycle latency
//   is_div   out  1   op uses the divide latency
module mdu_calc
   import mdu_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [31:0] hi,
   input  logic [31:0] lo,
   output dword_t      res,
   output logic        div_zero,
   output logic        is_long,
   output logic        is_div
);

   dword_t      prod_s, prod_u;
   logic [31:0] abs_a, abs_b, divisor_s, divisor_u;
   logic [31:0] quo_mag, rem_mag, quo_s, rem_s, quo_u, rem_u;

   // Signed divide via magnitudes avoids the 0x80000000 / -1 overflow case.
   always_comb begin
      prod_s    = dword_t'({{32{a[31]}}, a}) * dword_t'({{32{b[31]}}, b});
      prod_u    = dword_t'({32'd0, a}) * dword_t'({32'd0, b});
      abs_a     = a[31] ? (~a + 32'd1) : a;
      abs_b     = b[31] ? (~b + 32'd1) : b;
      // Divisor forced non-zero; a zero-divisor result is discarded anyway.
      divisor_s = (b == 32'd0) ? 32'd1 : abs_b;
      divisor_u = (b == 32'd0) ? 32'd1 : b;
      quo_mag   = abs_a / divisor_s;
      rem_mag   = abs_a % divisor_s;
      quo_s     = (a[31] ^ b[31]) ? (~quo_mag + 32'd1) : quo_mag;
      rem_s     = a[31] ? (~rem_mag + 32'd1) : rem_mag;
      quo_u     = a / divisor_u;
      rem_u     = a % divisor_u;
   end

`ifndef MDU_MADD_EN
   logic unused_acc;
   assign unused_acc = ^{hi, lo};
`endif

   always_comb begin
      res      = '0;
      div_zero = 1'b0;
      is_long  = 1'b0;
      is_div   = 1'b0;
      case (op)
         MDU_MULT: begin
            res     = prod_s;
            is_long = 1'b1;
         end
         MDU_MULTU: begin
            res     = prod_u;
            is_long = 1'b1;
         end
         MDU_DIV: begin
            res      = {rem_s, quo_s};
            is_long  = 1'b1;
            is_div   = 1'b1;
            div_zero = (b == 32'd0);
         end
         MDU_DIVU: begin
            res      = {rem_u, quo_u};
            is_long  = 1'b1;
            is_div   = 1'b1;
            div_zero = (b == 32'd0);
         end
`ifdef MDU_MADD_EN
         MDU_MADD: begin
            res     = {hi, lo} + prod_s;
            is_long = 1'b1;
         end
         MDU_MADDU: begin
            res     = {hi, lo} + prod_u;
            is_long = 1'b1;
         end
         MDU_MSUB: begin
            res     = {hi, lo} - prod_s;
            is_long = 1'b1;
         end
         MDU_MSUBU: begin
            res     = {hi, lo} - prod_u;
            is_long = 1'b1;
         end
`endif
         default: ;
      endcase
   end

endmodule

// File: rtl/mdu_unit.sv
// Multiply/divide unit beside the Execute stage; holds architectural HI/LO.
// Optional feature macro: MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU.
// Ports:
//   clk    in   1   rising-edge clock
//   reset  in   1   synchronous active-high reset, clears all state
//   start  in   1   op valid this cycle (unflushed Execute instruction)
//   op     in   4   operation code (see mdu_pkg)
//   a, b   in   32  rs/rt after forwarding
//   busy   out  1   long operation in flight
//   hi, lo out  32  architectural HI/LO
module mdu_unit
   import mdu_pkg::*;
#(
   parameter int unsigned MULT_LAT = MULT_LAT_DEF,
   parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int unsigned MaxLat = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
   localparam int unsigned CntW   = (MaxLat > 1) ? $clog2(MaxLat) : 1;

   mdu_state_e       state_q, state_d;
   logic [CntW-1:0]  count_q, count_d;
   logic [31:0]      hi_q, hi_d, lo_q, lo_d;
   dword_t           pend_q, pend_d;
   logic             pend_wr_q, pend_wr_d;

   dword_t calc_res;
   logic   calc_div_zero, calc_is_long, calc_is_div;

   mdu_calc u_calc (
      .op       (op),
      .a        (a),
      .b        (b),
      .hi       (hi_q),
      .lo       (lo_q),
      .res      (calc_res),
      .div_zero (calc_div_zero),
      .is_long  (calc_is_long),
      .is_div   (calc_is_div)
   );

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      pend_d    = pend_q;
      pend_wr_d = pend_wr_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               if (calc_is_long) begin
                  pend_d    = calc_res;
                  pend_wr_d = ~calc_div_zero;
                  count_d   = calc_is_div ? CntW'(DIV_LAT - 1) : CntW'(MULT_LAT - 1);
                  state_d   = StRun;
               end else if (op == MDU_MTHI) begin
                  hi_d = a;
               end else if (op == MDU_MTLO) begin
                  lo_d = a;
               end
            end
         end
         StRun: begin
            // Any start while running is ignored.
            if (count_q != '0) begin
               count_d = count_q - CntW'(1);
            end else begin
               if (pend_wr_q) begin
                  hi_d = pend_q[63:32];
                  lo_d = pend_q[31:0];
               end
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         count_q   <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         pend_q    <= '0;
         pend_wr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         pend_q    <= pend_d;
         pend_wr_q <= pend_wr_d;
      end
   end

   assign busy = (state_q == StRun);
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed cases plus randomized ops against a
// behavioural HI/LO model built from plain 64-bit arithmetic.
module tb_mdu_unit;
   import mdu_pkg::*;

   localparam int MultLat = 5;
   localparam int DivLat  = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [3:0]  op;
   logic [31:0] a, b;
   logic        busy;
   logic [31:0] hi, lo;

   int checks   = 0;
   int failures = 0;

   logic [31:0] m_hi, m_lo;

   mdu_unit #(
      .MULT_LAT (MultLat),
      .DIV_LAT  (DivLat)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .hi    (hi),
      .lo    (lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Architectural effect of one op on the model: latency and new HI/LO.
   task automatic model(input logic [3:0] mop, input logic [31:0] ma, input logic [31:0] mb,
                        output int lat, output logic [31:0] eh, output logic [31:0] el);
      longint          sa, sb, q, r;
      longint unsigned ua, ub, acc, p;
      logic [63:0]     v;
      lat = 0;
      eh  = m_hi;
      el  = m_lo;
      sa  = longint'($signed(ma));
      sb  = longint'($signed(mb));
      ua  = longint'({32'd0, ma});
      ub  = longint'({32'd0, mb});
      acc = {m_hi, m_lo};
      case (mop)
         MDU_MULT:  begin lat = MultLat; v = sa * sb; eh = v[63:32]; el = v[31:0]; end
         MDU_MULTU: begin lat = MultLat; v = ua * ub; eh = v[63:32]; el = v[31:0]; end
         MDU_DIV: begin
            lat = DivLat;
            if (mb != 0) begin
               q = sa / sb; r = sa % sb; v = {r[31:0], q[31:0]};
               eh = v[63:32]; el = v[31:0];
            end
         end
         MDU_DIVU: begin
            lat = DivLat;
            if (mb != 0) begin
               eh = 32'(ua % ub); el = 32'(ua / ub);
            end
         end
         MDU_MTHI: eh = ma;
         MDU_MTLO: el = ma;
`ifdef MDU_MADD_EN
         MDU_MADD:  begin lat = MultLat; v = acc + 64'(sa * sb); eh = v[63:32]; el = v[31:0]; end
         MDU_MADDU: begin lat = MultLat; p = ua * ub; v = acc + p; eh = v[63:32]; el = v[31:0]; end
         MDU_MSUB:  begin lat = MultLat; v = acc - 64'(sa * sb); eh = v[63:32]; el = v[31:0]; end
         MDU_MSUBU: begin lat = MultLat; p = ua * ub; v = acc - p; eh = v[63:32]; el = v[31:0]; end
`endif
         default: ;
      endcase
   endtask

   // Issue one op at a negedge; count busy cycles; check latency and final HI/LO.
   task automatic apply(input string tag, input logic [3:0] iop, input logic [31:0] ia,
                        input logic [31:0] ib);
      int lat, n;
      logic [31:0] eh, el;
      model(iop, ia, ib, lat, eh, el);
      start = 1'b1; op = iop; a = ia; b = ib;
      @(negedge clk);
      start = 1'b0; op = MDU_NOP;
      n = 0;
      while (busy === 1'b1 && n < 200) begin
         n++;
         @(negedge clk);
      end
      check({tag, ".busy_cycles"}, 64'(n), 64'(lat));
      check({tag, ".hi"}, {32'd0, hi}, {32'd0, eh});
      check({tag, ".lo"}, {32'd0, lo}, {32'd0, el});
      m_hi = eh;
      m_lo = el;
   endtask

   initial begin
      int n;
      int lat;
      logic [31:0] eh, el;
      logic [3:0]  rop;
      logic [31:0] ra, rb;

      reset = 1'b1; start = 1'b0; op = MDU_NOP; a = '0; b = '0;
      m_hi = '0; m_lo = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check("reset.busy", {63'd0, busy}, 64'd0);
      check("reset.hi", {32'd0, hi}, 64'd0);
      check("reset.lo", {32'd0, lo}, 64'd0);

      apply("mult_neg", MDU_MULT, 32'hFFFFFFFE, 32'd3);
      check("mult_neg.const_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);
      check("mult_neg.const_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFFA);
      apply("multu_max", MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      check("multu_max.const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
      apply("div_neg", MDU_DIV, 32'hFFFFFFF9, 32'd2);
      check("div_neg.const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      apply("div_ovf", MDU_DIV, 32'h80000000, 32'hFFFFFFFF);
      check("div_ovf.const", {hi, lo}, 64'h0000_0000_8000_0000);
      apply("mthi", MDU_MTHI, 32'h12345678, 32'd0);
      apply("divu_zero", MDU_DIVU, 32'd55, 32'd0);
      check("divu_zero.const_hi", {32'd0, hi}, 64'h0000_0000_1234_5678);

      // Reset on busy cycle 4 aborts the divide.
      start = 1'b1; op = MDU_DIVU; a = 32'd100; b = 32'd7;
      @(negedge clk);
      start = 1'b0; op = MDU_NOP;
      repeat (3) @(negedge clk);
      check("abort.busy_before", {63'd0, busy}, 64'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort.busy", {63'd0, busy}, 64'd0);
      check("abort.hilo", {hi, lo}, 64'd0);
      m_hi = '0; m_lo = '0;
      repeat (DivLat + 2) @(negedge clk);
      check("abort.no_late_commit", {hi, lo}, 64'd0);

      // Starts while busy are ignored; the divide commits on schedule.
      apply("pre_ovl_hi", MDU_MTHI, 32'hCAFEF00D, 32'd0);
      model(MDU_DIV, 32'd1000, 32'hFFFFFFF9, lat, eh, el);
      start = 1'b1; op = MDU_DIV; a = 32'd1000; b = 32'hFFFFFFF9;
      @(negedge clk);
      start = 1'b0; op = MDU_NOP;
      n = 0;
      while (busy === 1'b1 && n < 200) begin
         n++;
         if (n == 3) begin
            start = 1'b1; op = MDU_MULT; a = 32'd9; b = 32'd9;
         end else if (n == 5) begin
            start = 1'b1; op = MDU_MTLO; a = 32'hDEADBEEF;
         end else begin
            start = 1'b0; op = MDU_NOP;
         end
         @(negedge clk);
      end
      start = 1'b0; op = MDU_NOP;
      check("overlap.busy_cycles", 64'(n), 64'(lat));
      check("overlap.hilo", {hi, lo}, {eh, el});
      m_hi = eh; m_lo = el;
      @(negedge clk);
      check("overlap.idle_after", {63'd0, busy}, 64'd0);

`ifdef MDU_MADD_EN
      apply("madd_clr_hi", MDU_MTHI, 32'd0, 32'd0);
      apply("madd_lo", MDU_MTLO, 32'd10, 32'd0);
      apply("madd", MDU_MADD, 32'd3, 32'd4);
      check("madd.const", {hi, lo}, 64'd22);
      apply("msub", MDU_MSUB, 32'd5, 32'd5);
      check("msub.const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
`else
      apply("pre_nop", MDU_MTLO, 32'h0BADF00D, 32'd0);
      apply("madd_nop", MDU_MADD, 32'd3, 32'd4);
      apply("msubu_nop", MDU_MSUBU, 32'd3, 32'd4);
`endif
      apply("op12_nop", 4'd12, 32'd1, 32'd1);

      for (int i = 0; i < 40; i++) begin
         rop = 4'($urandom_range(0, 15));
         ra  = $urandom;
         rb  = ($urandom_range(0, 7) == 0) ? 32'd0 :
               ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
         if ($urandom_range(0, 3) == 0) ra = -32'($urandom_range(0, 1000));
         apply($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
